// File: rtl/fetch_buffer.sv
// Packet queue between I-cache fetch and 4-wide decode: show-ahead head,
// ready/valid pop, redirect kill that empties the queue in one edge.
module fetch_buffer #(
    parameter int WIDTH     = 32,
    parameter int WIDTH_PC  = 32,
    parameter int DEPTH     = 8,
    parameter int WIDTH_CNT = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [WIDTH_PC-1:0]  i_pc,
    input  logic [4*WIDTH-1:0]   i_data4x,
    input  logic [3:0]           i_mask,
    input  logic                 i_re,
    input  logic                 i_kill,
    output logic [4*WIDTH-1:0]   o_data4x,
    output logic [WIDTH_PC-1:0]  o_pc,
    output logic [3:0]           o_mask,
    output logic                 o_valid,
    output logic                 o_full,
    output logic [WIDTH_CNT-1:0] o_count,
    output logic                 o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [4*WIDTH-1:0]   data_q [DEPTH];
    logic [WIDTH_PC-1:0]  pc_q   [DEPTH];
    logic [3:0]           mask_q [DEPTH];

    logic [PTR_W-1:0]     wp_q, wp_d;
    logic [PTR_W-1:0]     rp_q, rp_d;
    logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 drop_q, drop_d;

    logic                 mask_any;
    logic                 push;
    logic                 pop;
    logic [3:0]           head_mask;

    assign mask_any = |i_mask;
    assign o_valid  = (cnt_q != '0);
    // Fullness comes from the current count, so a same-cycle pop cannot make room.
    assign push     = i_we & ~full_q & mask_any & ~i_kill;
    assign pop      = o_valid & i_re & ~i_kill;

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        drop_d = i_we & full_q & mask_any & ~i_kill;
        if (i_kill) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + WIDTH_CNT'(1);
                2'b01:   cnt_d = cnt_q - WIDTH_CNT'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        full_d = (cnt_d == WIDTH_CNT'(DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            drop_q <= drop_d;
        end
    end

    // Payload storage is never cleared; only pointers and count are reset.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            data_q[wp_q] <= i_data4x;
            pc_q[wp_q]   <= i_pc;
            mask_q[wp_q] <= i_mask;
        end
    end

    assign head_mask = mask_q[rp_q];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign o_mask[gi] = head_mask[gi] & o_valid;
        end
    endgenerate

    assign o_data4x = data_q[rp_q];
    assign o_pc     = pc_q[rp_q];
    assign o_full   = full_q;
    assign o_count  = cnt_q;
    assign o_drop   = drop_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised and directed stimulus for fetch_buffer, checked against a
// queue-based packet model.
module tb_fetch_buffer;

    localparam int WIDTH     = 32;
    localparam int WIDTH_PC  = 32;
    localparam int DEPTH     = 8;
    localparam int WIDTH_CNT = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we;
    logic [WIDTH_PC-1:0]  pc;
    logic [4*WIDTH-1:0]   data4x;
    logic [3:0]           mask;
    logic                 re;
    logic                 kill;
    logic [4*WIDTH-1:0]   o_data4x;
    logic [WIDTH_PC-1:0]  o_pc;
    logic [3:0]           o_mask;
    logic                 o_valid;
    logic                 o_full;
    logic [WIDTH_CNT-1:0] o_count;
    logic                 o_drop;

    always #5 clk = ~clk;

    fetch_buffer #(
        .WIDTH(WIDTH), .WIDTH_PC(WIDTH_PC), .DEPTH(DEPTH), .WIDTH_CNT(WIDTH_CNT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_pc(pc), .i_data4x(data4x),
        .i_mask(mask), .i_re(re), .i_kill(kill),
        .o_data4x(o_data4x), .o_pc(o_pc), .o_mask(o_mask), .o_valid(o_valid),
        .o_full(o_full), .o_count(o_count), .o_drop(o_drop)
    );

    typedef struct {
        logic [WIDTH_PC-1:0] pc;
        logic [3:0]          mask;
        logic [4*WIDTH-1:0]  data;
    } pkt_t;

    pkt_t q[$];
    logic exp_drop = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", cyc, tag, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare half a cycle later.
    task automatic cycle(input logic r, input logic w, input logic [WIDTH_PC-1:0] p,
                         input logic [3:0] m, input logic [4*WIDTH-1:0] d,
                         input logic rd, input logic k);
        logic full, do_push, do_pop;
        pkt_t pk;
        rst = r; we = w; pc = p; mask = m; data4x = d; re = rd; kill = k;
        @(posedge clk);
        if (r || k) begin
            q.delete();
            exp_drop = 1'b0;
        end else begin
            full     = (q.size() == DEPTH);
            do_push  = w && !full && (m != 4'b0);
            do_pop   = (q.size() != 0) && rd;
            exp_drop = w && full && (m != 4'b0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                pk.pc = p; pk.mask = m; pk.data = d;
                q.push_back(pk);
            end
        end
        @(negedge clk);
        cyc++;
        check("valid", 128'(o_valid), 128'(q.size() != 0));
        check("count", 128'(o_count), 128'(q.size()));
        check("full",  128'(o_full),  128'(q.size() == DEPTH));
        check("drop",  128'(o_drop),  128'(exp_drop));
        check("mask",  128'(o_mask),  (q.size() != 0) ? 128'(q[0].mask) : 128'(0));
        if (q.size() != 0) begin
            check("pc",   128'(o_pc), 128'(q[0].pc));
            check("data", o_data4x,   q[0].data);
        end
        $display("cyc=%0d rst=%0b we=%0b pc=%0h m=%0h re=%0b kill=%0b -> v=%0b cnt=%0d full=%0b drop=%0b hpc=%0h",
                 cyc, r, w, p, m, rd, k, o_valid, o_count, o_full, o_drop, o_pc);
    endtask

    function automatic logic [4*WIDTH-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; pc = '0; mask = '0; data4x = '0; re = 1'b0; kill = 1'b0;
        @(negedge clk);

        // Reset then single packet
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h100, 4'hF, {32'hB3, 32'h93, 32'h13, 32'h33}, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Fill and overflow, then drain
        for (int i = 0; i < 9; i++) cycle(0, 1, 32'(i * 16), 4'hF, rnd_data(), 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0, 1, 0);

        // Streaming across the pointer wrap
        cycle(0, 1, 32'h1000, 4'hF, rnd_data(), 0, 0);
        for (int i = 1; i <= 20; i++) cycle(0, 1, 32'(32'h1000 + i * 4), 4'hF, rnd_data(), 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Kill priority over push and pop
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'(32'h300 + i), 4'h3, rnd_data(), 0, 0);
        cycle(0, 1, 32'h3FF, 4'hF, rnd_data(), 1, 1);
        cycle(0, 1, 32'h200, 4'hF, rnd_data(), 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Mask handling
        cycle(0, 1, 32'h20, 4'h0, rnd_data(), 0, 0);
        cycle(0, 1, 32'h24, 4'hE, rnd_data(), 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) cycle(0, 1, 32'(32'h400 + i), 4'hF, rnd_data(), 0, 0);
        cycle(0, 1, 32'h4FF, 4'hF, rnd_data(), 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h500, 4'hF, rnd_data(), 1, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] m;
            m = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6), $urandom(), m,
                  rnd_data(), ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
